// File: rtl/sample_queue_pkg.sv
// sample_queue_pkg
// Shared definitions for the stereo sample queue: the control state type and
// the default geometry (sample width, RAM depth, filter tap count).
package sample_queue_pkg;

    // FILL: window not yet complete; IDLE: window complete, waiting;
    // SEQ: streaming the current window to the filter.
    typedef enum logic [1:0] {
        FILL = 2'd0,
        IDLE = 2'd1,
        SEQ  = 2'd2
    } sqState_e;

    localparam int SQ_DW    = 24;
    localparam int SQ_DEPTH = 1024;
    localparam int SQ_TAPS  = 1021;

endpackage

// File: rtl/sq_dpram.sv
// sq_dpram
// Simple dual-port RAM holding {left, right} sample pairs.
// One write port, one synchronous (registered) read port, single clock.
// Ports:
//   clk       - clock, rising edge
//   wrEn_i    - write enable
//   wrAddr_i  - write address
//   wrData_i  - write data {left, right}
//   rdEn_i    - read enable; rdData_o updates one clock after the address
//   rdAddr_i  - read address
//   rdData_o  - registered read data
module sq_dpram
    import sample_queue_pkg::*;
#(
    parameter int DEPTH = SQ_DEPTH,
    parameter int WIDTH = 2 * SQ_DW,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wrEn_i,
    input  logic [AW-1:0]    wrAddr_i,
    input  logic [WIDTH-1:0] wrData_i,
    input  logic             rdEn_i,
    input  logic [AW-1:0]    rdAddr_i,
    output logic [WIDTH-1:0] rdData_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdData_q;

    // No reset on the array or read register so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wrEn_i) begin
            mem[wrAddr_i] <= wrData_i;
        end
        if (rdEn_i) begin
            rdData_q <= mem[rdAddr_i];
        end
    end

    assign rdData_o = rdData_q;

endmodule

// File: rtl/sample_queue.sv
// sample_queue
// Stereo circular sample buffer between the I2S receiver and the FIR stage.
// Every strobed left/right pair is written to RAM; once TAPS pairs are held,
// each new pair launches a sequence that streams the newest TAPS pairs,
// oldest first, one pair per clock.
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   wrt_smpl   - one-cycle strobe, lft_smpl/rght_smpl valid
//   lft_smpl   - left sample in
//   rght_smpl  - right sample in
//   sequencing - high while lft_out/rght_out carry a streamed pair
//   lft_out    - streamed left sample (holds between sequences)
//   rght_out   - streamed right sample (holds between sequences)
//   ovr        - sticky overrun flag
// Build option:
//   SAMPLE_QUEUE_OVR_DET_EN - when defined, ovr sets on a strobe arriving
//   while a sequence is running; otherwise ovr is tied low.
module sample_queue
    import sample_queue_pkg::*;
#(
    parameter int DEPTH = SQ_DEPTH,
    parameter int TAPS  = SQ_TAPS,
    parameter int DW    = SQ_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wrt_smpl,
    input  logic [DW-1:0] lft_smpl,
    input  logic [DW-1:0] rght_smpl,
    output logic          sequencing,
    output logic [DW-1:0] lft_out,
    output logic [DW-1:0] rght_out,
    output logic          ovr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TAPS + 1);
    localparam int RW = $clog2(TAPS);

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] FILL_LAST = CW'(TAPS - 1);
    localparam logic [RW-1:0] RD_ONE    = RW'(1);
    localparam logic [RW-1:0] RD_LAST   = RW'(TAPS - 1);

    sqState_e        state_q, state_d;
    logic [AW-1:0]   newPtr_q, newPtr_d;
    logic [AW-1:0]   oldPtr_q, oldPtr_d;
    logic [AW-1:0]   rdPtr_q, rdPtr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   rdCnt_q, rdCnt_d;
    logic            rdVld_q;
    logic            seq_q;
    logic [DW-1:0]   lft_q, rght_q;
    logic [2*DW-1:0] rdData;
    logic            rdEn;

    // A read address is issued on every cycle spent in SEQ.
    assign rdEn = (state_q == SEQ);

    sq_dpram #(
        .DEPTH (DEPTH),
        .WIDTH (2 * DW),
        .AW    (AW)
    ) u_ram (
        .clk      (clk),
        .wrEn_i   (wrt_smpl),
        .wrAddr_i (newPtr_q),
        .wrData_i ({lft_smpl, rght_smpl}),
        .rdEn_i   (rdEn),
        .rdAddr_i (rdPtr_q),
        .rdData_o (rdData)
    );

    // Every strobe is written regardless of state. A strobe during SEQ still
    // slides the window (old_ptr) but leaves the running read walk alone.
    always_comb begin
        state_d  = state_q;
        newPtr_d = newPtr_q;
        oldPtr_d = oldPtr_q;
        rdPtr_d  = rdPtr_q;
        cnt_d    = cnt_q;
        rdCnt_d  = rdCnt_q;

        case (state_q)
            FILL: begin
                if (wrt_smpl) begin
                    newPtr_d = newPtr_q + PTR_ONE;
                    cnt_d    = cnt_q + CNT_ONE;
                    if (cnt_q == FILL_LAST) begin
                        rdPtr_d = oldPtr_q;
                        rdCnt_d = '0;
                        state_d = SEQ;
                    end
                end
            end
            IDLE: begin
                if (wrt_smpl) begin
                    newPtr_d = newPtr_q + PTR_ONE;
                    oldPtr_d = oldPtr_q + PTR_ONE;
                    rdPtr_d  = oldPtr_q + PTR_ONE;
                    rdCnt_d  = '0;
                    state_d  = SEQ;
                end
            end
            SEQ: begin
                rdPtr_d = rdPtr_q + PTR_ONE;
                rdCnt_d = rdCnt_q + RD_ONE;
                if (rdCnt_q == RD_LAST) begin
                    state_d = IDLE;
                end
                if (wrt_smpl) begin
                    newPtr_d = newPtr_q + PTR_ONE;
                    oldPtr_d = oldPtr_q + PTR_ONE;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Control state, pointers and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FILL;
            newPtr_q <= '0;
            oldPtr_q <= '0;
            rdPtr_q  <= '0;
            cnt_q    <= '0;
            rdCnt_q  <= '0;
        end else begin
            state_q  <= state_d;
            newPtr_q <= newPtr_d;
            oldPtr_q <= oldPtr_d;
            rdPtr_q  <= rdPtr_d;
            cnt_q    <= cnt_d;
            rdCnt_q  <= rdCnt_d;
        end
    end

    // Output stage: the valid bit follows the read address through the RAM
    // register, then data and sequencing are registered together. Data holds
    // its last streamed value between sequences.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdVld_q <= 1'b0;
            seq_q   <= 1'b0;
            lft_q   <= '0;
            rght_q  <= '0;
        end else begin
            rdVld_q <= rdEn;
            seq_q   <= rdVld_q;
            if (rdVld_q) begin
                lft_q  <= rdData[2*DW-1:DW];
                rght_q <= rdData[DW-1:0];
            end
        end
    end

    assign sequencing = seq_q;
    assign lft_out    = lft_q;
    assign rght_out   = rght_q;

`ifdef SAMPLE_QUEUE_OVR_DET_EN
    logic ovr_q;

    // Sticky until reset: any strobe that lands while a sequence runs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_q <= 1'b0;
        end else if (wrt_smpl && (state_q == SEQ)) begin
            ovr_q <= 1'b1;
        end
    end

    assign ovr = ovr_q;
`else
    assign ovr = 1'b0;
`endif

endmodule

// File: tb/tb_sample_queue.sv
// tb_sample_queue
// Self-checking bench for sample_queue with DEPTH=8, TAPS=5, DW=24.
// A history-queue model predicts, for every cycle, whether a streamed pair
// is due and which one; directed scenarios pin the model with literal values.
module tb_sample_queue;

    localparam int DEPTH = 8;
    localparam int TAPS  = 5;
    localparam int DW    = 24;

`ifdef SAMPLE_QUEUE_OVR_DET_EN
    localparam logic OVR_EN = 1'b1;
`else
    localparam logic OVR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wrt_smpl = 1'b0;
    logic [DW-1:0] lft_smpl = '0;
    logic [DW-1:0] rght_smpl = '0;
    logic          sequencing;
    logic [DW-1:0] lft_out;
    logic [DW-1:0] rght_out;
    logic          ovr;

    int testsRun = 0;
    int testsFailed = 0;

    sample_queue #(
        .DEPTH (DEPTH),
        .TAPS  (TAPS),
        .DW    (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wrt_smpl   (wrt_smpl),
        .lft_smpl   (lft_smpl),
        .rght_smpl  (rght_smpl),
        .sequencing (sequencing),
        .lft_out    (lft_out),
        .rght_out   (rght_out),
        .ovr        (ovr)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: keep the newest TAPS strobed pairs. A strobe is an
    // overrun if it lands within the TAPS read cycles after the last
    // launching strobe; otherwise, with a full window, it launches a
    // sequence whose pairs appear after edges e+2 .. e+TAPS+1.
    int            cyc = 0;
    int            lastTrig = -1000;
    logic [DW-1:0] histL[$];
    logic [DW-1:0] histR[$];
    logic [DW-1:0] expL[int];
    logic [DW-1:0] expR[int];
    logic          expOvr = 1'b0;
    logic [DW-1:0] holdL = '0;
    logic [DW-1:0] holdR = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            histL.delete();
            histR.delete();
            expL.delete();
            expR.delete();
            expOvr = 1'b0;
            lastTrig = -1000;
        end else begin
            cyc++;
            if (wrt_smpl) begin
                histL.push_back(lft_smpl);
                histR.push_back(rght_smpl);
                if (histL.size() > TAPS) begin
                    void'(histL.pop_front());
                    void'(histR.pop_front());
                end
                if (cyc >= lastTrig + 1 && cyc <= lastTrig + TAPS) begin
                    expOvr = expOvr | OVR_EN;
                end else if (histL.size() == TAPS) begin
                    lastTrig = cyc;
                    for (int i = 0; i < TAPS; i++) begin
                        expL[cyc + 2 + i] = histL[i];
                        expR[cyc + 2 + i] = histR[i];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            holdL = '0;
            holdR = '0;
        end else begin
            if (expL.exists(cyc)) begin
                checkOutput("sequencing", 32'(sequencing), 32'd1);
                checkOutput("lft_out", 32'(lft_out), 32'(expL[cyc]));
                checkOutput("rght_out", 32'(rght_out), 32'(expR[cyc]));
                holdL = expL[cyc];
                holdR = expR[cyc];
                expL.delete(cyc);
                expR.delete(cyc);
            end else begin
                checkOutput("sequencing", 32'(sequencing), 32'd0);
                checkOutput("lft_out hold", 32'(lft_out), 32'(holdL));
                checkOutput("rght_out hold", 32'(rght_out), 32'(holdR));
            end
            checkOutput("ovr", 32'(ovr), 32'(expOvr));
        end
    end

    task automatic applyStimulus(input logic [DW-1:0] l, input logic [DW-1:0] r);
        @(posedge clk);
        #2;
        wrt_smpl  = 1'b1;
        lft_smpl  = l;
        rght_smpl = r;
        @(posedge clk);
        #2;
        wrt_smpl  = 1'b0;
    endtask

    task automatic strobeK(input int k);
        applyStimulus(DW'(k), DW'(32'h800000 + k));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    logic [DW-1:0] capL[TAPS];
    logic [DW-1:0] capR[TAPS];
    int            capFound;
    int            capDelay;
    int            capRun;

    // Wait (bounded) for sequencing, then record TAPS consecutive pairs.
    task automatic captureSeq(input int budget);
        capFound = 0;
        capDelay = 0;
        capRun   = 0;
        for (int i = 0; i < budget && capFound == 0; i++) begin
            @(negedge clk);
            capDelay = i + 1;
            if (sequencing) capFound = 1;
        end
        if (capFound != 0) begin
            capL[0] = lft_out;
            capR[0] = rght_out;
            capRun  = 1;
            for (int j = 1; j < TAPS; j++) begin
                @(negedge clk);
                capL[j] = lft_out;
                capR[j] = rght_out;
                if (sequencing && capRun == j) capRun++;
            end
        end
    endtask

    task automatic checkSeq(input string name, input int base);
        checkOutput({name, " found"}, 32'(capFound), 32'd1);
        checkOutput({name, " run length"}, 32'(capRun), 32'(TAPS));
        for (int j = 0; j < TAPS; j++) begin
            checkOutput($sformatf("%s lft[%0d]", name, j), 32'(capL[j]), 32'(base + j));
            checkOutput($sformatf("%s rght[%0d]", name, j), 32'(capR[j]), 32'h800000 + 32'(base + j));
        end
    endtask

    initial begin
        idle(3);
        #2;
        checkOutput("reset sequencing", 32'(sequencing), 32'd0);
        checkOutput("reset lft_out", 32'(lft_out), 32'd0);
        checkOutput("reset rght_out", 32'(rght_out), 32'd0);
        checkOutput("reset ovr", 32'(ovr), 32'd0);
        rst = 1'b0;

        // Fill: no output until the window is complete.
        for (int k = 1; k <= 4; k++) begin
            strobeK(k);
            captureSeq(8);
            checkOutput("fill no sequence", 32'(capFound), 32'd0);
        end
        strobeK(5);
        captureSeq(10);
        checkOutput("fill start delay", 32'(capDelay), 32'd3);
        checkSeq("fill", 1);

        idle(2);
        strobeK(6);
        captureSeq(10);
        checkSeq("slide", 2);

        // Wrap across RAM address 7 -> 0.
        for (int k = 7; k <= 11; k++) begin
            strobeK(k);
            idle(8);
        end
        strobeK(12);
        captureSeq(10);
        checkSeq("wrap", 8);

        // Overrun: second strobe two cycles into a running sequence.
        idle(2);
        strobeK(13);
        fork
            captureSeq(10);
            strobeK(14);
        join
        checkSeq("overrun", 9);
        idle(1);
        #2;
        checkOutput("overrun ovr flag", 32'(ovr), 32'(OVR_EN));
        idle(4);
        strobeK(15);
        captureSeq(10);
        checkSeq("after overrun", 11);

        // Reset in the middle of a sequence.
        idle(2);
        strobeK(16);
        repeat (2) @(posedge clk);
        #2;
        checkOutput("sequencing before reset", 32'(sequencing), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("midrun reset sequencing", 32'(sequencing), 32'd0);
        checkOutput("midrun reset lft_out", 32'(lft_out), 32'd0);
        checkOutput("midrun reset rght_out", 32'(rght_out), 32'd0);
        checkOutput("midrun reset ovr", 32'(ovr), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        for (int k = 21; k <= 24; k++) begin
            strobeK(k);
            captureSeq(8);
            checkOutput("post reset no sequence", 32'(capFound), 32'd0);
        end
        strobeK(25);
        captureSeq(10);
        checkSeq("post reset", 21);

        // Legal back-to-back spacing of TAPS+2 cycles.
        idle(2);
        for (int k = 26; k <= 31; k++) begin
            strobeK(k);
            idle(5);
        end
        idle(10);
        checkOutput("back-to-back ovr", 32'(ovr), 32'd0);

        // Randomized traffic, mixing legal spacing with overruns.
        for (int n = 0; n < 80; n++) begin
            applyStimulus(DW'($urandom), DW'($urandom));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(0, 2)));
            else idle(int'($urandom_range(5, 10)));
        end
        idle(TAPS + 6);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
